// File: rtl/sp_ram_requester.sv
// rtl/sp_ram_requester.sv - valid/ready request front-end for a single-port no-change RAM
//
// Purpose
//   Accepts read/write requests, drives a 1-cycle-latency single-port RAM directly
//   from the accepted request and returns read data in request order through a
//   2-entry response FIFO with a same-cycle bypass.
//   Optional feature macro: SP_RAM_REQUESTER_SCRUB_EN (zero-fill the RAM during INIT).
//
// Ports
//   clka, rsta_n                     clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_addr, req_wdata      request payload (1 = write)
//   resp_valid/resp_ready, resp_data read response stream
//   ena, wea, regcea, addra, dina    RAM control/address/write data
//   rsta                             RAM output reset (tied 0)
//   douta                            RAM read data
//   init_done                        high while in RUN
module sp_ram_requester #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  localparam int ADDR_W = $clog2(RAM_DEPTH-1)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RAM_WIDTH-1:0] resp_data,
  output logic                 ena,
  output logic                 wea,
  output logic                 regcea,
  output logic [ADDR_W-1:0]    addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 rsta,
  input  logic [RAM_WIDTH-1:0] douta,
  output logic                 init_done
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [1:0]           count_q, count_d;
  logic                 in_flight_q;
  logic                 rd_ptr_q, wr_ptr_q;
  logic [RAM_WIDTH-1:0] fifo_q [2];

  logic accept, rd_accept, pop, fifo_pop, store, init_finish;
  logic [2:0] occupancy;

  // Outstanding reads = queued responses + the read currently inside the RAM.
  assign occupancy = {1'b0, count_q} + {2'b00, in_flight_q};
  assign req_ready = (state_q == S_RUN) && (occupancy < 3'd2);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;

  // With an empty FIFO the RAM output is presented directly, so a read answers
  // one cycle after acceptance; douta holds its value, keeping the bypass stable.
  assign resp_valid = (count_q != 2'd0) | in_flight_q;
  assign resp_data  = (count_q == 2'd0) ? douta : fifo_q[rd_ptr_q];
  assign pop        = resp_valid & resp_ready;
  assign fifo_pop   = pop & (count_q != 2'd0);
  // A returning word consumed straight off the bypass is never stored.
  assign store      = in_flight_q & ~(pop & (count_q == 2'd0));

  assign regcea    = 1'b1;
  assign rsta      = 1'b0;
  assign init_done = (state_q == S_RUN);

`ifdef SP_RAM_REQUESTER_SCRUB_EN
  // scrub_go_q keeps the RAM idle while reset is held; scrubbing starts on the
  // first edge after release.
  logic              scrub_go_q;
  logic [ADDR_W-1:0] scrub_addr_q;
  logic              scrub_we;

  assign scrub_we    = (state_q == S_INIT) & scrub_go_q;
  assign init_finish = scrub_we && (scrub_addr_q == ADDR_W'(RAM_DEPTH-1));

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      scrub_go_q   <= 1'b0;
      scrub_addr_q <= '0;
    end else begin
      scrub_go_q <= 1'b1;
      if (scrub_we) scrub_addr_q <= scrub_addr_q + 1'b1;
    end
  end

  assign ena   = accept | scrub_we;
  assign wea   = (accept & req_we) | scrub_we;
  assign addra = scrub_we ? scrub_addr_q : req_addr;
  assign dina  = scrub_we ? '0 : req_wdata;
`else
  assign init_finish = 1'b1;
  assign ena         = accept;
  assign wea         = accept & req_we;
  assign addra       = req_addr;
  assign dina        = req_wdata;
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_finish) state_d = S_RUN;
  end

  always_comb begin
    count_d = count_q;
    if (store && !fifo_pop)      count_d = count_q + 2'd1;
    else if (!store && fifo_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q     <= S_INIT;
      count_q     <= 2'd0;
      in_flight_q <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_flight_q <= rd_accept;
      if (store) begin
        fifo_q[wr_ptr_q] <= douta;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_sp_ram_requester.sv
// tb/tb_sp_ram_requester.sv - self-checking bench for sp_ram_requester
module tb_sp_ram_requester;
  localparam int W     = 18;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH-1);

  logic          clka = 1'b0;
  logic          rsta_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          req_ready, resp_valid, ena, wea, regcea, rsta, init_done;
  logic [W-1:0]  resp_data, dina;
  logic [AW-1:0] addra;
  logic [W-1:0]  douta = '0;

  always #5 clka = ~clka;

  sp_ram_requester #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
    .clka(clka), .rsta_n(rsta_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ena(ena), .wea(wea), .regcea(regcea), .addra(addra), .dina(dina),
    .rsta(rsta), .douta(douta), .init_done(init_done)
  );

  // No-change single-port RAM, 1-cycle read latency.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clka) begin
    if (ena) begin
      if (wea) ram[addra] <= dina;
      else     douta <= ram[addra];
    end
  end

  // Reference: memory image plus an ordered list of responses still owed.
  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          v, we;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          rr;
    logic          x_rdy, x_rv;
    logic [W-1:0]  x_data;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic rr,
                      output logic o_rdy, output logic o_rv, output logic [W-1:0] o_data);
    logic acc;
    @(negedge clka);
    o_rdy = req_ready; o_rv = resp_valid; o_data = resp_data;
    check("req_ready", 32'(req_ready), 32'(exp_q.size() < 2));
    check("resp_valid", 32'(resp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("resp_data", 32'(resp_data), 32'(exp_q[0]));
    check("init_done", 32'(init_done), 32'd1);
    check("no_overflow", 32'(dut.in_flight_q && dut.count_q == 2'd2), 32'd0);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; resp_ready = rr;
    #1;
    acc = v && (exp_q.size() < 2);
    check("ena", 32'(ena), 32'(acc));
    check("wea", 32'(wea), 32'(acc && we));
    if (acc) check("addra", 32'(addra), 32'(a));
    if (acc && we) check("dina", 32'(dina), 32'(d));
    if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc && we)  ref_mem[a] = d;
    if (acc && !we) exp_q.push_back(ref_mem[a]);
  endtask

  task automatic idle(input logic rr);
    logic r0, r1;
    logic [W-1:0] r2;
    step(1'b0, 1'b0, '0, '0, rr, r0, r1, r2);
  endtask

  task automatic do_reset();
    @(negedge clka);
    rsta_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; resp_ready = 1'b1;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ena", 32'(ena), 32'd0);
    exp_q.delete();
`ifdef SP_RAM_REQUESTER_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    @(negedge clka);
    @(negedge clka);
    rsta_n = 1'b1; req_valid = 1'b0;
    #1;
    check("init_after_release", 32'(init_done), 32'd0);
  endtask

  task automatic wait_init();
    int n = 0;
    int wr = 0;
    bit done = 1'b0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      @(negedge clka);
      n++;
      if (init_done) begin
        done = 1'b1;
        break;
      end
      if (ena && wea) begin
        check("scrub_addr", 32'(addra), 32'(wr));
        check("scrub_dina", 32'(dina), 32'd0);
        wr++;
      end
    end
    check("init_timeout", 32'(done), 32'd1);
`ifdef SP_RAM_REQUESTER_SCRUB_EN
    check("scrub_writes", 32'(wr), 32'(DEPTH));
`else
    check("init_cycles", 32'(n), 32'd1);
    check("init_ram_idle", 32'(wr), 32'd0);
`endif
  endtask

  initial begin
    logic o_rdy, o_rv;
    logic [W-1:0] o_data;

    for (int i = 0; i < DEPTH; i++) begin
`ifdef SP_RAM_REQUESTER_SCRUB_EN
      ram[i] = 18'h3FFFF;
      ref_mem[i] = '0;
`else
      ram[i] = W'(32'h1000 + i * 7);
      ref_mem[i] = W'(32'h1000 + i * 7);
`endif
    end

    do_reset();
    wait_init();

    // Read back the whole RAM (all zero after a scrub).
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1, o_rdy, o_rv, o_data);
    idle(1'b1);
    idle(1'b1);

    // Write-then-read and back-pressure with four queued reads.
    tbl[0]  = '{1'b1, 1'b1, 4'd5, 18'h2A,  1'b1, 1'b1, 1'b0, 18'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'd5, 18'h0,   1'b1, 1'b1, 1'b0, 18'h0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 18'h0,   1'b1, 1'b1, 1'b1, 18'h2A};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 18'h0,   1'b0, 1'b1, 1'b0, 18'h0};
    tbl[4]  = '{1'b1, 1'b1, 4'd0, 18'h100, 1'b0, 1'b1, 1'b0, 18'h0};
    tbl[5]  = '{1'b1, 1'b1, 4'd1, 18'h101, 1'b0, 1'b1, 1'b0, 18'h0};
    tbl[6]  = '{1'b1, 1'b1, 4'd2, 18'h102, 1'b0, 1'b1, 1'b0, 18'h0};
    tbl[7]  = '{1'b1, 1'b1, 4'd3, 18'h103, 1'b0, 1'b1, 1'b0, 18'h0};
    tbl[8]  = '{1'b1, 1'b0, 4'd0, 18'h0,   1'b0, 1'b1, 1'b0, 18'h0};
    tbl[9]  = '{1'b1, 1'b0, 4'd1, 18'h0,   1'b0, 1'b1, 1'b1, 18'h100};
    tbl[10] = '{1'b1, 1'b0, 4'd2, 18'h0,   1'b0, 1'b0, 1'b1, 18'h100};
    tbl[11] = '{1'b1, 1'b0, 4'd2, 18'h0,   1'b0, 1'b0, 1'b1, 18'h100};
    tbl[12] = '{1'b1, 1'b0, 4'd2, 18'h0,   1'b1, 1'b0, 1'b1, 18'h100};
    tbl[13] = '{1'b1, 1'b0, 4'd2, 18'h0,   1'b1, 1'b1, 1'b1, 18'h101};
    tbl[14] = '{1'b1, 1'b0, 4'd3, 18'h0,   1'b1, 1'b1, 1'b1, 18'h102};
    tbl[15] = '{1'b0, 1'b0, 4'd0, 18'h0,   1'b1, 1'b1, 1'b1, 18'h103};
    tbl[16] = '{1'b0, 1'b0, 4'd0, 18'h0,   1'b1, 1'b1, 1'b0, 18'h0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr, o_rdy, o_rv, o_data);
      check($sformatf("tbl%0d_rdy", i), 32'(o_rdy), 32'(tbl[i].x_rdy));
      check($sformatf("tbl%0d_rv", i), 32'(o_rv), 32'(tbl[i].x_rv));
      if (tbl[i].x_rv) check($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].x_data));
    end

    // Streaming reads with the consumer always ready: full throughput.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, AW'($urandom_range(0, DEPTH-1)), '0, 1'b1, o_rdy, o_rv, o_data);
      check("stream_rdy", 32'(o_rdy), 32'd1);
      if (i > 0) check("stream_rv", 32'(o_rv), 32'd1);
    end
    idle(1'b1);
    idle(1'b1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, DEPTH-1)), W'($urandom), $urandom_range(0, 3) != 0,
           o_rdy, o_rv, o_data);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset with responses pending: nothing stale may come out afterwards.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 4'd3, '0, 1'b0, o_rdy, o_rv, o_data);
      step(1'b1, 1'b0, 4'd7, '0, 1'b0, o_rdy, o_rv, o_data);
      if (k == 1) idle(1'b0);
      do_reset();
      wait_init();
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'b0, '0, '0, 1'b1, o_rdy, o_rv, o_data);
        check("post_reset_rv", 32'(o_rv), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
